// File: rtl/regfile_issue_ctrl.sv
// Issue and writeback controller for the 32-entry 3R/1W FP register file.
// Scoreboard blocks RAW/WAW hazards; one write port shared by results and loads.
module regfile_issue_ctrl #(
    parameter int LATENCY = 4,
    parameter int OPW     = 4,
    parameter int AW      = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [OPW-1:0] instr_op,
    input  logic [AW-1:0]  instr_a,
    input  logic [AW-1:0]  instr_b,
    input  logic [AW-1:0]  instr_c,
    input  logic [AW-1:0]  instr_w,
    output logic [AW-1:0]  rd_addr_a,
    output logic [AW-1:0]  rd_addr_b,
    output logic [AW-1:0]  rd_addr_c,
    output logic           issue_valid,
    output logic [OPW-1:0] issue_op,
    input  logic           ld_valid,
    input  logic [AW-1:0]  ld_addr,
    output logic           ld_ready,
    output logic           wb_we,
    output logic [AW-1:0]  wb_addr,
    output logic           ld_sel,
    output logic           busy
);

    localparam int NREG = 1 << AW;
    // The last stage of the writeback pipe is the wb_* register itself.
    localparam int WBS  = LATENCY - 1;

    logic [NREG-1:0] r_pending;
    logic [WBS:1]    r_sr_v;
    logic [AW-1:0]   r_sr_addr [1:WBS];

    logic            w_ld_grant;
    logic            w_ld_hazard;
    logic            w_src_busy;
    logic            w_issue;
    logic [NREG-1:0] w_pending_next;

    assign w_ld_grant  = ld_valid && !rst && !r_sr_v[WBS] && !r_pending[ld_addr];
    assign w_ld_hazard = w_ld_grant && ((ld_addr == instr_a) || (ld_addr == instr_b) ||
                                        (ld_addr == instr_c) || (ld_addr == instr_w));
    assign w_src_busy  = r_pending[instr_a] || r_pending[instr_b] ||
                         r_pending[instr_c] || r_pending[instr_w];
    assign instr_ready = !rst && !w_src_busy && !w_ld_hazard;
    assign w_issue     = instr_valid && instr_ready;
    assign ld_ready    = w_ld_grant;
    assign busy        = |r_pending;

    // Clear uses the registered pending bit, so a clearing entry still blocks issue.
    always_comb begin
        w_pending_next = r_pending;
        if (wb_we && !ld_sel)
            w_pending_next[wb_addr] = 1'b0;
        if (w_issue)
            w_pending_next[instr_w] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_sr_v      <= '0;
            for (int k = 1; k <= WBS; k++)
                r_sr_addr[k] <= '0;
            rd_addr_a   <= '0;
            rd_addr_b   <= '0;
            rd_addr_c   <= '0;
            issue_valid <= 1'b0;
            issue_op    <= '0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            ld_sel      <= 1'b0;
        end else begin
            r_pending    <= w_pending_next;
            r_sr_v[1]    <= w_issue;
            r_sr_addr[1] <= instr_w;
            for (int k = 2; k <= WBS; k++) begin
                r_sr_v[k]    <= r_sr_v[k-1];
                r_sr_addr[k] <= r_sr_addr[k-1];
            end
            issue_valid <= w_issue;
            if (w_issue) begin
                rd_addr_a <= instr_a;
                rd_addr_b <= instr_b;
                rd_addr_c <= instr_c;
                issue_op  <= instr_op;
            end
            wb_we   <= r_sr_v[WBS] || w_ld_grant;
            wb_addr <= r_sr_v[WBS] ? r_sr_addr[WBS] : ld_addr;
            ld_sel  <= !r_sr_v[WBS];
        end
    end

endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// Scoreboard bench for regfile_issue_ctrl: expected writebacks are queued at
// accept/grant time and matched against wb_* when they come due.
module tb_regfile_issue_ctrl;
    localparam int L   = 4;
    localparam int OPW = 4;
    localparam int AW  = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           instr_valid;
    logic           instr_ready;
    logic [OPW-1:0] instr_op;
    logic [AW-1:0]  instr_a, instr_b, instr_c, instr_w;
    logic [AW-1:0]  rd_addr_a, rd_addr_b, rd_addr_c;
    logic           issue_valid;
    logic [OPW-1:0] issue_op;
    logic           ld_valid;
    logic [AW-1:0]  ld_addr;
    logic           ld_ready;
    logic           wb_we;
    logic [AW-1:0]  wb_addr;
    logic           ld_sel;
    logic           busy;

    regfile_issue_ctrl #(.LATENCY(L), .OPW(OPW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_a(instr_a), .instr_b(instr_b), .instr_c(instr_c), .instr_w(instr_w),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
        .wb_we(wb_we), .wb_addr(wb_addr), .ld_sel(ld_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic        sel;
    } wb_t;

    wb_t          sbq[$];
    logic [31:0]  m_pend;
    int           cyc;
    int           n_tests = 0;
    int           n_fail  = 0;
    logic         e_iv;
    logic [AW-1:0] e_ra, e_rb, e_rc;
    logic [OPW-1:0] e_op;
    logic         rst_seen;
    logic         acc;
    logic         dut_acc;
    logic         dut_lr;
    logic         dut_ir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        int            due_idx;
        logic          res_next;
        logic          exp_lr, exp_ir;
        logic          clr;
        logic [AW-1:0] clr_addr;
        @(negedge clk);
        due_idx  = -1;
        res_next = 1'b0;
        clr      = 1'b0;
        clr_addr = '0;
        foreach (sbq[i]) begin
            if (sbq[i].cyc == cyc) due_idx = i;
            if (sbq[i].cyc == cyc + 1 && !sbq[i].sel) res_next = 1'b1;
        end
        if (due_idx >= 0) begin
            chk("wb_we", 32'(wb_we), 32'd1);
            chk("wb_addr", 32'(wb_addr), 32'(sbq[due_idx].addr));
            chk("ld_sel", 32'(ld_sel), 32'(sbq[due_idx].sel));
            clr      = !sbq[due_idx].sel;
            clr_addr = sbq[due_idx].addr;
            sbq.delete(due_idx);
        end else begin
            chk("wb_we_idle", 32'(wb_we), 32'd0);
            if (rst_seen) begin
                chk("wb_addr_rst", 32'(wb_addr), 32'd0);
                chk("ld_sel_rst", 32'(ld_sel), 32'd0);
            end
        end
        chk("issue_valid", 32'(issue_valid), 32'(e_iv));
        chk("rd_addr_a", 32'(rd_addr_a), 32'(e_ra));
        chk("rd_addr_b", 32'(rd_addr_b), 32'(e_rb));
        chk("rd_addr_c", 32'(rd_addr_c), 32'(e_rc));
        chk("issue_op", 32'(issue_op), 32'(e_op));
        chk("busy", 32'(busy), 32'(|m_pend));

        exp_lr = !rst && ld_valid && !res_next && !m_pend[ld_addr];
        exp_ir = !rst && !m_pend[instr_a] && !m_pend[instr_b] && !m_pend[instr_c] &&
                 !m_pend[instr_w] &&
                 !(exp_lr && (ld_addr == instr_a || ld_addr == instr_b ||
                              ld_addr == instr_c || ld_addr == instr_w));
        chk("ld_ready", 32'(ld_ready), 32'(exp_lr));
        chk("instr_ready", 32'(instr_ready), 32'(exp_ir));
        dut_lr  = ld_ready;
        dut_ir  = instr_ready;
        dut_acc = instr_valid && instr_ready;
        acc     = instr_valid && exp_ir;

        if (rst) begin
            sbq.delete();
            m_pend   = '0;
            e_iv     = 1'b0;
            e_ra     = '0;
            e_rb     = '0;
            e_rc     = '0;
            e_op     = '0;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (clr) m_pend[clr_addr] = 1'b0;
            if (exp_lr) sbq.push_back('{cyc + 1, ld_addr, 1'b1});
            e_iv = acc;
            if (acc) begin
                sbq.push_back('{cyc + L, instr_w, 1'b0});
                m_pend[instr_w] = 1'b1;
                e_ra = instr_a;
                e_rb = instr_b;
                e_rc = instr_c;
                e_op = instr_op;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic offer(input int a, input int b, input int c, input int w, input int op);
        instr_valid = 1'b1;
        instr_a  = AW'(a);
        instr_b  = AW'(b);
        instr_c  = AW'(c);
        instr_w  = AW'(w);
        instr_op = OPW'(op);
    endtask

    task automatic drain(input int n);
        instr_valid = 1'b0;
        ld_valid    = 1'b0;
        repeat (n) tick();
    endtask

    int t0;
    int acc_cyc;

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0; instr_op = '0;
        instr_a = '0; instr_b = '0; instr_c = '0; instr_w = '0;
        ld_valid = 1'b0; ld_addr = '0;
        cyc = 0;
        sbq.delete();
        m_pend = '0; e_iv = 1'b0; e_ra = '0; e_rb = '0; e_rc = '0; e_op = '0;
        rst_seen = 1'b1; acc = 1'b0; dut_acc = 1'b0; dut_lr = 1'b0; dut_ir = 1'b0;
        @(posedge clk); #1;
        tick();
        tick();
        rst = 1'b0;

        // 1: single issue, writeback at t0+L
        t0 = cyc;
        offer(1, 2, 3, 5, 7);
        tick();
        chk("t1_accept", 32'(dut_acc), 32'd1);
        drain(7);

        // 2: RAW stall until the result has been written back
        t0 = cyc;
        offer(1, 2, 3, 5, 1);
        tick();
        offer(5, 0, 0, 6, 2);
        acc_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dut_acc) begin
                acc_cyc = cyc - 1;
                break;
            end
        end
        chk("t2_accept_cycle", 32'(acc_cyc - t0), 32'd5);
        drain(8);

        // 3: back-to-back independent issues
        for (int i = 0; i < 4; i++) begin
            offer(20 + i, 24 + i, 28 + i, 8 + i, i);
            tick();
            chk("t3_no_stall", 32'(dut_acc), 32'd1);
        end
        drain(8);

        // 4: load held against an in-flight result
        offer(0, 0, 0, 6, 3);
        ld_valid = 1'b1;
        ld_addr  = 5'd7;
        tick();
        chk("t4_ld_grant_t0", 32'(dut_lr), 32'd1);
        instr_valid = 1'b0;
        tick(); tick();
        tick();
        chk("t4_ld_block_t3", 32'(dut_lr), 32'd0);
        repeat (4) tick();
        drain(6);

        // 5: load to a source register wins; instruction follows next cycle
        ld_valid = 1'b1;
        ld_addr  = 5'd2;
        offer(4, 2, 12, 13, 5);
        tick();
        chk("t5_ld_grant", 32'(dut_lr), 32'd1);
        chk("t5_instr_blocked", 32'(dut_ir), 32'd0);
        ld_valid = 1'b0;
        tick();
        chk("t5_instr_next", 32'(dut_acc), 32'd1);
        drain(8);

        // 6: reset while a result is in flight
        offer(0, 0, 0, 3, 6);
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        offer(3, 0, 0, 14, 4);
        tick();
        chk("t6_issue_after_rst", 32'(dut_acc), 32'd1);
        drain(8);

        // random mix with a small address range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_a  = AW'($urandom_range(0, 7));
            instr_b  = AW'($urandom_range(0, 7));
            instr_c  = AW'($urandom_range(0, 7));
            instr_w  = AW'($urandom_range(0, 7));
            instr_op = OPW'($urandom_range(0, 15));
            ld_valid = 1'($urandom_range(0, 2) == 0);
            ld_addr  = AW'($urandom_range(0, 7));
            rst      = 1'($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        drain(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_issue_ctrl.md
Name: regfile_issue_ctrl

Overview:
Issue and writeback controller for the iterative FP datapath's 32-entry, 3-read/1-write distributed-RAM register file. It accepts 3-source/1-destination instructions and drives the register file read addresses (A, B, C). It tracks in-flight results with a scoreboard and a fixed-latency writeback shift register. It also arbitrates the single write port between datapath results and an external load port.

Parameters:
LATENCY, 4, cycles from issue to result writeback; legal range 2..16.
OPW, 4, opcode width passed through to the datapath.
AW, 5, register address width (32 entries).

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
instr_valid  in  1  instruction offered.
instr_ready  out  1  combinational; instruction accepted this cycle when both valid and ready are 1.
instr_op  in  OPW  opcode.
instr_a  in  AW  source A address.
instr_b  in  AW  source B address.
instr_c  in  AW  source C address.
instr_w  in  AW  destination address.
rd_addr_a  out  AW  register file read address A (registered).
rd_addr_b  out  AW  register file read address B (registered).
rd_addr_c  out  AW  register file read address C (registered).
issue_valid  out  1  registered; operands on the register file read ports are valid this cycle.
issue_op  out  OPW  registered opcode to the datapath.
ld_valid  in  1  load request.
ld_addr  in  AW  load destination address.
ld_ready  out  1  combinational; load granted this cycle.
wb_we  out  1  registered register file write enable.
wb_addr  out  AW  registered register file write address.
ld_sel  out  1  registered write-data select: 1 = load data, 0 = datapath result.
busy  out  1  OR of all scoreboard pending bits.

Behaviour:
- State: pending[31:0] scoreboard; shift register sr[1..LATENCY], each stage holding {v, addr}.
- Load grant (ld_ready = 1) requires all of:
  - ld_valid = 1;
  - !rst;
  - sr[LATENCY-1].v = 0 (the write port is free next cycle);
  - pending[ld_addr] = 0.
- Issue (instr_ready = 1) requires all of:
  - !rst;
  - pending[a], pending[b], pending[c] and pending[w] all 0 (RAW and WAW both stall);
  - no same-cycle load grant whose ld_addr equals a, b, c or w.
- Issue and a load grant to different addresses may occur in the same cycle.
- Same-cycle scoreboard: a pending bit being cleared this cycle still blocks issue; no bypass.
- On issue at cycle t:
  - At t+1: rd_addr_a/b/c = a/b/c, issue_op = op, issue_valid = 1.
  - When no issue occurs, issue_valid = 0 the next cycle and rd_addr_* / issue_op hold their values.
  - pending[w] is set at the edge ending t.
  - sr[1] is loaded with {1, w}; the shift register advances every cycle.
- Writeback, registered at each edge:
  - wb_we = sr[LATENCY-1].v OR ld_grant.
  - wb_addr = sr[LATENCY-1].addr if that stage is valid, else ld_addr.
  - ld_sel = !sr[LATENCY-1].v.
  - A result issued at t therefore appears with wb_we = 1 at t+LATENCY.
  - The two write sources never coincide, by construction of the grant rule.
- Pending clear:
  - Result writeback: in the cycle wb_we = 1 with ld_sel = 0, pending[wb_addr] clears at the end of that cycle.
  - Loads never set pending bits.
  - A dependent instruction issues no earlier than t+LATENCY+1, and its read sees the new value.
- Throughput: one issue per cycle when there are no hazards; the register file is written at most once per cycle.
- Reset (also mid-operation) sets all of the following to 0:
  - pending and all sr.v;
  - wb_we, issue_valid, ld_sel, busy;
  - rd_addr_*, wb_addr, issue_op.
  - In-flight results are discarded and no writeback occurs after reset.
  - While rst = 1, instr_ready and ld_ready are 0.

Test Plan:
1. LATENCY=4, reset, then issue {a=1, b=2, c=3, w=5} at t=0:
   - rd_addr = 1/2/3 and issue_valid = 1 at t=1;
   - busy = 1 from t=1;
   - wb_we = 1, wb_addr = 5, ld_sel = 0 at t=4;
   - busy = 0 at t=5.
2. RAW stall: issue w=5 at t=0, then offer a=5 from t=1:
   - instr_ready = 0 for t=1..4;
   - accepted at t=5, with rd_addr_a = 5 at t=6.
3. Back-to-back: four independent instructions with w = 8..11 at t=0..3:
   - all accepted with no stall;
   - wb_we = 1 at t=4..7 with wb_addr 8, 9, 10, 11.
4. Write-port conflict: issue w=6 at t=0, hold ld_valid with ld_addr=7 from t=0:
   - ld_ready = 0 at t=3;
   - granted at t=0 (wb at t=1, ld_sel = 1) and not at t=3;
   - the rule is re-checked by holding ld_valid continuously: no cycle has two write sources.
5. Load/issue interlock: ld_valid with ld_addr=2 and instruction b=2 in the same cycle:
   - load granted, instr_ready = 0;
   - instruction issues the next cycle.
6. Reset mid-op: issue w=3 at t=0, assert rst at t=2:
   - no wb_we at t=4;
   - busy = 0 and pending cleared;
   - an instruction with a=3 issues immediately after reset is released.
